// File: rtl/rv_pkg.sv
// Shared RV32 definitions used by the fetch stage and its neighbours.
// Holds the architectural word width and the two instruction encodings fetch cares about.
package rv_pkg;

    localparam int unsigned XLEN = 32;

    typedef logic [XLEN-1:0] instr_t;

    localparam instr_t RV_NOP    = 32'h0000_0013;
    localparam instr_t RV_EBREAK = 32'h0010_0073;

endpackage

// File: rtl/rv_ifetch.sv
// Instruction-fetch stage: owns the PC, drives rv_imem and feeds decode through a one-entry
// valid/ready slot. Handles redirect flushes, EBREAK halt and out-of-range fetch faults.
module rv_ifetch
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned WORDS    = 64
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        halted,
    output logic        fault,
    output logic [31:0] fetch_count
);

    logic [31:0] pc_q, pc_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_pc_q, if_pc_d;
    instr_t      if_instr_q, if_instr_d;
    logic        halted_q, halted_d;
    logic        fault_q, fault_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    logic take;
    logic redirect_go;
    logic can_fetch;
    logic in_range;
    logic is_ebreak;

    assign take        = if_valid_q && if_ready;
    assign redirect_go = redirect_valid && !halted_q;
    assign can_fetch   = !halted_q && !redirect_valid && (!if_valid_q || take);
    assign in_range    = (32'(pc_q[31:2]) < WORDS);
    assign is_ebreak   = (imem_rdata == RV_EBREAK);

    always_comb begin
        pc_d          = pc_q;
        if_valid_d    = if_valid_q;
        if_pc_d       = if_pc_q;
        if_instr_d    = if_instr_q;
        halted_d      = halted_q;
        fault_d       = fault_q;
        fetch_count_d = fetch_count_q;

        // The handshake counts even when a redirect flushes the slot on the same edge.
        if (take) begin
            fetch_count_d = fetch_count_q + 32'd1;
            if_valid_d    = 1'b0;
        end

        if (redirect_go) begin
            pc_d       = {redirect_pc[31:2], 2'b00};
            if_valid_d = 1'b0;
        end else if (can_fetch) begin
            if (in_range) begin
                if_pc_d    = pc_q;
                if_instr_d = imem_rdata;
                if_valid_d = 1'b1;
                pc_d       = pc_q + 32'd4;
                if (is_ebreak) begin
                    halted_d = 1'b1;
                end
            end else begin
                fault_d  = 1'b1;
                halted_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            if_valid_q    <= 1'b0;
            if_pc_q       <= 32'h0000_0000;
            if_instr_q    <= RV_NOP;
            halted_q      <= 1'b0;
            fault_q       <= 1'b0;
            fetch_count_q <= 32'h0000_0000;
        end else begin
            pc_q          <= pc_d;
            if_valid_q    <= if_valid_d;
            if_pc_q       <= if_pc_d;
            if_instr_q    <= if_instr_d;
            halted_q      <= halted_d;
            fault_q       <= fault_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign imem_addr   = pc_q;
    assign if_valid    = if_valid_q;
    assign if_pc       = if_pc_q;
    assign if_instr    = if_instr_q;
    assign halted      = halted_q;
    assign fault       = fault_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_rv_ifetch.sv
// Directed bench for rv_ifetch with a small combinational instruction memory model.
// Expected values are hand-derived from the default program image.
module tb_rv_ifetch;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        halted;
    logic        fault;
    logic [31:0] fetch_count;

    int unsigned n_checks;
    int unsigned n_errors;

    logic [31:0] mem [64];
    logic [31:0] prog [6];

    rv_ifetch #(
        .RESET_PC (32'h0000_0000),
        .WORDS    (64)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .halted         (halted),
        .fault          (fault),
        .fetch_count    (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Out-of-range reads return zero; the DUT must not load them anyway.
    always_comb begin
        imem_rdata = 32'h0000_0000;
        if (imem_addr[31:8] == 24'h0) imem_rdata = mem[imem_addr[7:2]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        if_ready       = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        prog[0] = 32'h001000B7;
        prog[1] = 32'h0000A087;
        prog[2] = 32'h0040A107;
        prog[3] = 32'h102081D3;
        prog[4] = 32'h0030A427;
        prog[5] = 32'h00100073;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0013;
        for (int i = 0; i < 6; i++) mem[i] = prog[i];

        // Reset state
        do_reset();
        check("rst_valid", {31'b0, if_valid}, 32'd0);
        check("rst_if_pc", if_pc, 32'h0);
        check("rst_instr", if_instr, 32'h0000_0013);
        check("rst_halted", {31'b0, halted}, 32'd0);
        check("rst_fault", {31'b0, fault}, 32'd0);
        check("rst_count", fetch_count, 32'd0);
        check("rst_addr", imem_addr, 32'h0);

        // Straight-line run into EBREAK
        for (int i = 0; i < 6; i++) begin
            step();
            check($sformatf("run_valid%0d", i), {31'b0, if_valid}, 32'd1);
            check($sformatf("run_pc%0d", i), if_pc, 32'(4 * i));
            check($sformatf("run_instr%0d", i), if_instr, prog[i]);
            check($sformatf("run_count%0d", i), fetch_count, 32'(i));
        end
        check("ebreak_halted", {31'b0, halted}, 32'd1);
        check("ebreak_addr", imem_addr, 32'h18);
        step();
        check("drain_valid", {31'b0, if_valid}, 32'd0);
        check("drain_count", fetch_count, 32'd6);
        step();
        check("halt_valid", {31'b0, if_valid}, 32'd0);
        check("halt_addr", imem_addr, 32'h18);

        // Stall holds the slot
        do_reset();
        step();
        if_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("stall_valid%0d", i), {31'b0, if_valid}, 32'd1);
            check($sformatf("stall_pc%0d", i), if_pc, 32'h0);
            check($sformatf("stall_instr%0d", i), if_instr, 32'h001000B7);
            check($sformatf("stall_addr%0d", i), imem_addr, 32'h4);
            check($sformatf("stall_count%0d", i), fetch_count, 32'd0);
        end

        // Redirect while slot holds pc 0x4
        if_ready = 1'b1;
        step();
        check("pre_redir_pc", if_pc, 32'h4);
        check("pre_redir_count", fetch_count, 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_000E;
        if_ready       = 1'b0;
        step();
        redirect_valid = 1'b0;
        if_ready       = 1'b1;
        check("redir_valid", {31'b0, if_valid}, 32'd0);
        check("redir_addr", imem_addr, 32'hC);
        check("redir_count", fetch_count, 32'd1);
        step();
        check("redir_slot_valid", {31'b0, if_valid}, 32'd1);
        check("redir_slot_pc", if_pc, 32'hC);
        check("redir_slot_instr", if_instr, 32'h102081D3);

        // Out-of-range redirect faults
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        step();
        redirect_valid = 1'b0;
        check("oor_redir_valid", {31'b0, if_valid}, 32'd0);
        check("oor_redir_fault", {31'b0, fault}, 32'd0);
        step();
        check("oor_fault", {31'b0, fault}, 32'd1);
        check("oor_halted", {31'b0, halted}, 32'd1);
        check("oor_valid", {31'b0, if_valid}, 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        step();
        redirect_valid = 1'b0;
        step();
        check("oor_sticky_fault", {31'b0, fault}, 32'd1);
        check("oor_sticky_halted", {31'b0, halted}, 32'd1);
        check("oor_sticky_valid", {31'b0, if_valid}, 32'd0);
        check("oor_ignore_redir", imem_addr, 32'h100);

        // Reset mid-stall
        do_reset();
        step();
        step();
        if_ready = 1'b0;
        step();
        check("pre_rst_valid", {31'b0, if_valid}, 32'd1);
        check("pre_rst_count", fetch_count, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_valid", {31'b0, if_valid}, 32'd0);
        check("midrst_addr", imem_addr, 32'h0);
        check("midrst_count", fetch_count, 32'd0);
        check("midrst_halted", {31'b0, halted}, 32'd0);
        check("midrst_instr", if_instr, 32'h0000_0013);

        // Redirect beats an EBREAK fetch, take still counted
        do_reset();
        for (int i = 0; i < 5; i++) step();
        check("pre_eb_pc", if_pc, 32'h10);
        check("pre_eb_addr", imem_addr, 32'h14);
        check("pre_eb_count", fetch_count, 32'd4);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0008;
        step();
        redirect_valid = 1'b0;
        check("eb_redir_halted", {31'b0, halted}, 32'd0);
        check("eb_redir_count", fetch_count, 32'd5);
        check("eb_redir_valid", {31'b0, if_valid}, 32'd0);
        step();
        check("eb_redir_slot_pc", if_pc, 32'h8);
        check("eb_redir_slot_instr", if_instr, 32'h0040A107);
        check("eb_redir_no_halt", {31'b0, halted}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
